mem_responder: RTL and testbench

Word-addressed data-memory responder. It sits on the far side of the processor's load/store port and services one request at a time over a valid/ready request channel and a valid/ready response channel. Its access latency is parameterised, so pipeline and multicycle cores can be tested against realistic memory wait states. Byte-enable writes are supported. Misaligned or out-of-range accesses return an error response and change no memory contents.

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_array.sv | 31 +++
 rtl/mem_responder.sv | 72 +++++++
 tb/tb_mem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, widths and helpers for the memory responder
package mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int LAT_W = 4;
  localparam int WORD_BYTES = 4;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;
  function automatic logic is_aligned(input logic [31:0] a);
    return (a & 32'(WORD_BYTES - 1)) == '0;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 word store, byte-enable write, registered read, async clear
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic                     i_clr,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_be,
  output logic [31:0]              o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  // Read register holds 0 except after a load, so it doubles as the response data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_en && i_we)
        for (int b = 0; b < WORD_BYTES; b++)
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      r_rdata <= i_clr ? '0 : (i_en && !i_we) ? r_mem[i_addr] : r_rdata;
    end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder with fixed access latency
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  state_t r_state, w_next;
  logic [LAT_W-1:0] r_cnt;
  logic r_write, r_rsp_valid, r_rsp_err;
  logic [31:0] r_addr, r_wdata;
  logic [3:0] r_be;
  logic w_accept, w_commit, w_hs, w_err;
  assign w_accept = r_state == S_IDLE && req_valid;
  assign w_commit = r_state == S_WAIT && r_cnt == '0;
  assign w_hs     = r_state == S_RESP && rsp_ready;
  assign w_err    = !is_aligned(r_addr) || r_addr[31:2] >= 30'(DEPTH);
  // Every request passes through WAIT for LATENCY+1 cycles, so the
  // response lands exactly 1+LATENCY edges after acceptance
  always_comb
    w_next = w_accept ? S_WAIT : w_commit ? S_RESP : w_hs ? S_IDLE : r_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= ERR_NONE;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_accept ? LAT_W'(LATENCY) : (r_state == S_WAIT) ? r_cnt - 1'b1 : r_cnt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      r_rsp_valid <= w_commit ? 1'b1 : w_hs ? 1'b0 : r_rsp_valid;
      r_rsp_err   <= w_commit ? (w_err ? ERR_ACCESS : ERR_NONE) : w_hs ? ERR_NONE : r_rsp_err;
    end
  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_commit && !w_err),
    .i_we    (r_write),
    .i_clr   (w_hs),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (rsp_rdata)
  );
  assign req_ready = r_state == S_IDLE;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed traffic checked against a transaction-level model
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int LATENCY = 2;
  logic clk = 0, rst = 0, req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int n_chk = 0, n_pass = 0;
  bit started = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  // Transaction-level model: one request in flight, response 1+LATENCY edges after accept
  logic [31:0] m_mem [DEPTH];
  bit m_busy, e_valid, e_err, p_write;
  logic [31:0] e_rdata, p_addr, p_wdata;
  logic [3:0] p_be;
  int m_left;
  function automatic bit legal(input logic [31:0] a);
    return a % 4 == 0 && a < 32'(DEPTH * 4);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_busy <= 0; m_left <= 0; e_valid <= 0; e_err <= 0; e_rdata <= '0;
    end else if (e_valid) begin
      if (rsp_ready) begin e_valid <= 0; e_err <= 0; e_rdata <= '0; end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 0;
        e_valid <= 1;
        e_err   <= !legal(p_addr);
        e_rdata <= (legal(p_addr) && !p_write) ? m_mem[widx(p_addr)] : '0;
        if (legal(p_addr) && p_write) m_mem[widx(p_addr)] <= merge(m_mem[widx(p_addr)], p_wdata, p_be);
      end
    end else if (req_valid) begin
      m_busy <= 1; m_left <= LATENCY + 1;
      p_write <= req_write; p_addr <= req_addr; p_wdata <= req_wdata; p_be <= req_be;
    end
  always @(negedge clk)
    if (started)
      chk("cycle rdy/vld/err/data", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}),
          64'({!(m_busy || e_valid), e_valid, e_err, e_rdata}));
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bit acc = 0;
    int t = 0;
    @(posedge clk); #2;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    do begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); t++;
    end while (!acc && t < 50);
    if (!acc) chk("accept timeout", 0, 1);
    #2 req_valid = 0;
  endtask
  task automatic wait_rsp(input bit poke, output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++; #2;
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1)); req_write = 1; req_addr = 0;
        req_wdata = $urandom; req_be = 4'hF;
      end
    end while (!rsp_valid && lat < 100);
  endtask
  task automatic finish_rsp(input int hold, output logic [31:0] rd, output logic err);
    rsp_ready = 0;
    repeat (hold) @(posedge clk);
    if (hold > 0) #2;
    req_valid = 0; rsp_ready = 1; rd = rsp_rdata; err = rsp_err;
    @(posedge clk); #2 rsp_ready = 0;
  endtask
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input int hold, input bit poke, output logic [31:0] rd, output logic err);
    int lat;
    issue(w, a, d, be);
    wait_rsp(poke, lat);
    chk("latency", 64'(lat), 64'(LATENCY + 1));
    finish_rsp(hold, rd, err);
  endtask
  initial begin
    logic [31:0] rd, a;
    logic err;
    int lat, r;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    started = 1;
    rst = 0;
    txn(1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, rd, err);
    chk("st08 err", 64'(err), 0);
    chk("st08 rdata", 64'(rd), 0);
    txn(0, 32'h08, 0, 4'h0, 0, 0, rd, err);
    chk("ld08", 64'(rd), 64'h0000_0000_DEADBEEF);
    txn(1, 32'h08, 32'h11, 4'b0001, 0, 0, rd, err);
    txn(0, 32'h08, 0, 4'hF, 0, 0, rd, err);
    chk("ld08 be0001", 64'(rd), 64'h0000_0000_DEADBE11);
    txn(1, 32'h08, 32'hFFFFFFFF, 4'h0, 0, 0, rd, err);
    chk("st be0 err", 64'(err), 0);
    txn(0, 32'h08, 0, 4'hF, 0, 0, rd, err);
    chk("ld08 after be0", 64'(rd), 64'h0000_0000_DEADBE11);
    txn(0, 32'h0A, 0, 4'hF, 0, 0, rd, err);
    chk("ld0A err", 64'(err), 1);
    chk("ld0A rdata", 64'(rd), 0);
    txn(1, 32'h10, 32'h12345678, 4'hF, 0, 0, rd, err);
    txn(1, 32'h00, 32'hCAFEF00D, 4'hF, 0, 0, rd, err);
    txn(1, 32'h400, 32'hAAAAAAAA, 4'hF, 0, 0, rd, err);
    chk("st400 err", 64'(err), 1);
    txn(0, 32'h00, 0, 4'hF, 0, 0, rd, err);
    chk("ld00 after st400", 64'(rd), 64'h0000_0000_CAFEF00D);
    txn(0, 32'h10, 0, 4'hF, 5, 1, rd, err);
    chk("ld10 backpressure", 64'(rd), 64'h0000_0000_12345678);
    txn(0, 32'h00, 0, 4'hF, 0, 0, rd, err);
    chk("ld00 after pokes", 64'(rd), 64'h0000_0000_CAFEF00D);
    issue(0, 32'h10, 0, 4'hF);
    wait_rsp(0, lat);
    @(negedge clk); #2 rst = 1;
    #1 chk("async reset outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
    @(negedge clk) rst = 0;
    txn(0, 32'h10, 0, 4'hF, 0, 0, rd, err);
    chk("ld10 after reset", 64'(rd), 0);
    issue(1, 32'h04, 32'h55555555, 4'hF);
    @(posedge clk); #3 rst = 1;
    @(negedge clk) rst = 0;
    repeat (6) @(posedge clk);
    #2 chk("aborted no rsp", 64'(rsp_valid), 0);
    txn(0, 32'h04, 0, 4'hF, 0, 0, rd, err);
    chk("ld04 after abort", 64'(rd), 0);
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      a = r < 6 ? 32'(4 * $urandom_range(0, 31)) :
          r == 6 ? 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3)) :
          r == 7 ? 32'(DEPTH * 4 + 4 * $urandom_range(0, 1000)) :
          r == 8 ? 32'(DEPTH * 4 - 4) : ($urandom | 32'h8000_0000);
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), rd, err);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
